// File: rtl/clock_calendar_core.sv
// clock_calendar_core
// Single-clock real-time clock/calendar (2000-2099, leap years) with an
// internal clock-enable prescaler, a 12h/24h display toggle and a
// button-driven set mode (RUN -> YEAR -> MONTH -> DAY -> HOUR -> MIN -> RUN).
//
// Ports:
//   clk                 system clock, all registers on rising edge
//   rst_n               asynchronous active-low reset
//   fast                1 = FAST_DIV cycles per tick, 0 = CLK_HZ cycles per tick
//   mode_pulse          one-cycle pulse, toggles 12h/24h display
//   set_pulse           one-cycle pulse, enters set mode / advances field
//   inc_pulse           one-cycle pulse, increments the field being set
//   sel[1:0]            page: 00=00SS, 01=HHMM, 10=MMDD, 11=20YY
//   digit3..digit0      BCD digits of the selected page (digit3 leftmost)
//   pm                  internal hour >= 12
//   mode_24h            0 = 12h display, 1 = 24h display
//   field[2:0]          0 RUN, 1 YEAR, 2 MONTH, 3 DAY, 4 HOUR, 5 MIN
module clock_calendar_core #(
    parameter int CLK_HZ   = 10_000_000,
    parameter int FAST_DIV = 40
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       fast,
    input  logic       mode_pulse,
    input  logic       set_pulse,
    input  logic       inc_pulse,
    input  logic [1:0] sel,
    output logic [3:0] digit3,
    output logic [3:0] digit2,
    output logic [3:0] digit1,
    output logic [3:0] digit0,
    output logic       pm,
    output logic       mode_24h,
    output logic [2:0] field
);

    localparam logic [31:0] DIV_SLOW = CLK_HZ;
    localparam logic [31:0] DIV_FAST = FAST_DIV;

    typedef enum logic [2:0] {
        ST_RUN   = 3'd0,
        ST_YEAR  = 3'd1,
        ST_MONTH = 3'd2,
        ST_DAY   = 3'd3,
        ST_HOUR  = 3'd4,
        ST_MIN   = 3'd5
    } state_t;

    state_t      r_state;
    state_t      w_next_state;
    logic [31:0] r_cnt;
    logic [31:0] w_div;
    logic        w_tick;
    logic [5:0]  r_sec;
    logic [5:0]  r_min;
    logic [4:0]  r_hour;
    logic [4:0]  r_day;
    logic [3:0]  r_month;
    logic [6:0]  r_year;
    logic        r_mode_24h;
    logic [4:0]  w_dim;
    logic [4:0]  w_hour_disp;
    logic [15:0] w_digits;

    // Days in month; year is 0..99 so year%4 is its two low bits.
    function automatic logic [4:0] days_in_month(input logic [3:0] m, input logic [6:0] y);
        case (m)
            4'd4, 4'd6, 4'd9, 4'd11: days_in_month = 5'd30;
            4'd2:                    days_in_month = (y[1:0] == 2'b00) ? 5'd29 : 5'd28;
            default:                 days_in_month = 5'd31;
        endcase
    endfunction

    // Binary 0..99 to two BCD digits.
    function automatic logic [7:0] to_bcd(input logic [6:0] v);
        to_bcd = (8'(v / 7'd10) << 3'd4) | 8'(v % 7'd10);
    endfunction

    assign w_div  = fast ? DIV_FAST : DIV_SLOW;
    assign w_tick = (r_state == ST_RUN) && (r_cnt >= (w_div - 32'd1));
    assign w_dim  = days_in_month(r_month, r_year);

    // Prescaler: free-runs only in RUN; held at 0 in every set state so the
    // first tick after leaving set mode comes a full period later.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= 32'd0;
        end else if ((r_state != ST_RUN) || w_tick || set_pulse) begin
            r_cnt <= 32'd0;
        end else begin
            r_cnt <= r_cnt + 32'd1;
        end
    end

    // Set-field state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_RUN;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Set-field sequencing on set_pulse.
    always_comb begin
        w_next_state = r_state;
        if (set_pulse) begin
            case (r_state)
                ST_RUN:   w_next_state = ST_YEAR;
                ST_YEAR:  w_next_state = ST_MONTH;
                ST_MONTH: w_next_state = ST_DAY;
                ST_DAY:   w_next_state = ST_HOUR;
                ST_HOUR:  w_next_state = ST_MIN;
                ST_MIN:   w_next_state = ST_RUN;
                default:  w_next_state = ST_RUN;
            endcase
        end else begin
            w_next_state = r_state;
        end
    end

    // 12h/24h display toggle, independent of set mode.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mode_24h <= 1'b0;
        end else if (mode_pulse) begin
            r_mode_24h <= ~r_mode_24h;
        end
    end

    // Time/date registers: carry chain on tick in RUN, per-field wrap in set mode.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sec   <= 6'd0;
            r_min   <= 6'd0;
            r_hour  <= 5'd0;
            r_day   <= 5'd1;
            r_month <= 4'd1;
            r_year  <= 7'd0;
        end else begin
            case (r_state)
                ST_RUN: begin
                    if (w_tick) begin
                        if (r_sec == 6'd59) begin
                            r_sec <= 6'd0;
                            if (r_min == 6'd59) begin
                                r_min <= 6'd0;
                                if (r_hour == 5'd23) begin
                                    r_hour <= 5'd0;
                                    if (r_day >= w_dim) begin
                                        r_day <= 5'd1;
                                        if (r_month == 4'd12) begin
                                            r_month <= 4'd1;
                                            r_year  <= (r_year >= 7'd99) ? 7'd0 : r_year + 7'd1;
                                        end else begin
                                            r_month <= r_month + 4'd1;
                                        end
                                    end else begin
                                        r_day <= r_day + 5'd1;
                                    end
                                end else begin
                                    r_hour <= r_hour + 5'd1;
                                end
                            end else begin
                                r_min <= r_min + 6'd1;
                            end
                        end else begin
                            r_sec <= r_sec + 6'd1;
                        end
                    end
                end
                ST_YEAR: begin
                    if (!set_pulse && inc_pulse) begin
                        r_year <= (r_year >= 7'd99) ? 7'd0 : r_year + 7'd1;
                    end
                end
                ST_MONTH: begin
                    // Leaving MONTH: pull day back inside the (possibly shorter) month.
                    if (set_pulse) begin
                        if (r_day > w_dim) begin
                            r_day <= w_dim;
                        end
                    end else if (inc_pulse) begin
                        r_month <= (r_month >= 4'd12) ? 4'd1 : r_month + 4'd1;
                    end
                end
                ST_DAY: begin
                    if (!set_pulse && inc_pulse) begin
                        r_day <= (r_day >= w_dim) ? 5'd1 : r_day + 5'd1;
                    end
                end
                ST_HOUR: begin
                    if (!set_pulse && inc_pulse) begin
                        r_hour <= (r_hour >= 5'd23) ? 5'd0 : r_hour + 5'd1;
                    end
                end
                ST_MIN: begin
                    // Returning to RUN starts the minute from zero seconds.
                    if (set_pulse) begin
                        r_sec <= 6'd0;
                    end else if (inc_pulse) begin
                        r_min <= (r_min >= 6'd59) ? 6'd0 : r_min + 6'd1;
                    end
                end
                default: begin
                    r_sec <= r_sec;
                end
            endcase
        end
    end

    // Hour as displayed: 12h mode maps 0 -> 12 and 13..23 -> 1..11.
    always_comb begin
        w_hour_disp = r_hour;
        if (r_mode_24h) begin
            w_hour_disp = r_hour;
        end else if (r_hour == 5'd0) begin
            w_hour_disp = 5'd12;
        end else if (r_hour > 5'd12) begin
            w_hour_disp = r_hour - 5'd12;
        end else begin
            w_hour_disp = r_hour;
        end
    end

    // Page select to four BCD digits.
    always_comb begin
        w_digits = 16'd0;
        case (sel)
            2'b00:   w_digits = {8'h00, to_bcd({1'b0, r_sec})};
            2'b01:   w_digits = {to_bcd({2'b00, w_hour_disp}), to_bcd({1'b0, r_min})};
            2'b10:   w_digits = {to_bcd({3'b000, r_month}), to_bcd({2'b00, r_day})};
            2'b11:   w_digits = {8'h20, to_bcd(r_year)};
            default: w_digits = 16'd0;
        endcase
    end

    assign digit3   = w_digits[15:12];
    assign digit2   = w_digits[11:8];
    assign digit1   = w_digits[7:4];
    assign digit0   = w_digits[3:0];
    assign pm       = (r_hour >= 5'd12);
    assign mode_24h = r_mode_24h;
    assign field    = r_state;

endmodule

// File: tb/tb_clock_calendar_core.sv
// Testbench for clock_calendar_core (CLK_HZ=10, FAST_DIV=2).
// Stimulus pushes expected {digits, pm, mode_24h, field} into a queue; a
// monitor on the falling clock edge pops and compares against the outputs.
module tb_clock_calendar_core;

    logic       clk;
    logic       rst_n;
    logic       fast;
    logic       mode_pulse;
    logic       set_pulse;
    logic       inc_pulse;
    logic [1:0] sel;
    logic [3:0] digit3;
    logic [3:0] digit2;
    logic [3:0] digit1;
    logic [3:0] digit0;
    logic       pm;
    logic       mode_24h;
    logic [2:0] field;

    int checks;
    int errors;

    logic [20:0] q_exp[$];
    string       q_name[$];

    clock_calendar_core #(
        .CLK_HZ  (10),
        .FAST_DIV(2)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .fast      (fast),
        .mode_pulse(mode_pulse),
        .set_pulse (set_pulse),
        .inc_pulse (inc_pulse),
        .sel       (sel),
        .digit3    (digit3),
        .digit2    (digit2),
        .digit1    (digit1),
        .digit0    (digit0),
        .pm        (pm),
        .mode_24h  (mode_24h),
        .field     (field)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Monitor: compare every queued expectation on the falling edge.
    always @(negedge clk) begin
        logic [20:0] exp_v;
        logic [20:0] act_v;
        string       nm;
        if (q_exp.size() > 0) begin
            exp_v = q_exp.pop_front();
            nm    = q_name.pop_front();
            act_v = {digit3, digit2, digit1, digit0, pm, mode_24h, field};
            checks++;
            if (act_v !== exp_v) begin
                errors++;
                $display("FAIL %s: got digits=%h pm=%b m24=%b field=%0d, expected digits=%h pm=%b m24=%b field=%0d",
                         nm, act_v[20:5], act_v[4], act_v[3], act_v[2:0],
                         exp_v[20:5], exp_v[4], exp_v[3], exp_v[2:0]);
            end
        end
    end

    // Select a page, queue the expectation, let the monitor take it.
    task automatic expect_out(input string nm, input logic [1:0] s, input logic [15:0] dig,
                              input logic p, input logic m, input logic [2:0] f);
        sel = s;
        q_name.push_back(nm);
        q_exp.push_back({dig, p, m, f});
        @(negedge clk);
        #1;
    endtask

    task automatic pulse_set();
        @(posedge clk); #1 set_pulse = 1'b1;
        @(posedge clk); #1 set_pulse = 1'b0;
    endtask

    task automatic pulse_inc();
        @(posedge clk); #1 inc_pulse = 1'b1;
        @(posedge clk); #1 inc_pulse = 1'b0;
    endtask

    task automatic pulse_mode();
        @(posedge clk); #1 mode_pulse = 1'b1;
        @(posedge clk); #1 mode_pulse = 1'b0;
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst_n = 1'b0; fast = 1'b0;
        set_pulse = 1'b0; inc_pulse = 1'b0; mode_pulse = 1'b0;
        @(posedge clk);
        @(posedge clk); #1 rst_n = 1'b1;
    endtask

    // From RUN right after reset: set the fields, ending in MIN.
    task automatic set_datetime(input int yr, input int mo, input int dy, input int hr, input int mn);
        pulse_set();
        repeat (yr) pulse_inc();
        pulse_set();
        repeat (mo - 1) pulse_inc();
        pulse_set();
        repeat (dy - 1) pulse_inc();
        pulse_set();
        repeat (hr) pulse_inc();
        pulse_set();
        repeat (mn) pulse_inc();
    endtask

    // Exit set mode, run exactly 60 fast ticks, then freeze in YEAR.
    task automatic run_minute_and_freeze();
        fast = 1'b1;
        pulse_set();
        repeat (119) @(posedge clk);
        pulse_set();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        checks = 0; errors = 0;
        rst_n = 1'b0; fast = 1'b0; sel = 2'b00;
        set_pulse = 1'b0; inc_pulse = 1'b0; mode_pulse = 1'b0;

        // Reset state.
        @(posedge clk); #1;
        expect_out("rst_sec",   2'b00, 16'h0000, 1'b0, 1'b0, 3'd0);
        expect_out("rst_hhmm",  2'b01, 16'h1200, 1'b0, 1'b0, 3'd0);
        expect_out("rst_mmdd",  2'b10, 16'h0101, 1'b0, 1'b0, 3'd0);
        expect_out("rst_year",  2'b11, 16'h2000, 1'b0, 1'b0, 3'd0);

        // First tick lands on the 10th edge after release.
        @(posedge clk); #1 rst_n = 1'b1;
        repeat (9) @(posedge clk);
        #1;
        expect_out("tick_early", 2'b00, 16'h0000, 1'b0, 1'b0, 3'd0);
        @(posedge clk); #1;
        expect_out("tick_first", 2'b00, 16'h0001, 1'b0, 1'b0, 3'd0);

        // Year rollover in 24h mode.
        do_reset();
        set_datetime(0, 12, 31, 23, 59);
        pulse_mode();
        run_minute_and_freeze();
        expect_out("roll_year", 2'b11, 16'h2001, 1'b0, 1'b1, 3'd1);
        expect_out("roll_date", 2'b10, 16'h0101, 1'b0, 1'b1, 3'd1);
        expect_out("roll_time", 2'b01, 16'h0000, 1'b0, 1'b1, 3'd1);
        expect_out("roll_sec",  2'b00, 16'h0000, 1'b0, 1'b1, 3'd1);
        repeat (50) @(posedge clk);
        #1;
        expect_out("set_hold",  2'b00, 16'h0000, 1'b0, 1'b1, 3'd1);
        // set_pulse and inc_pulse together: advance only.
        @(posedge clk); #1 set_pulse = 1'b1; inc_pulse = 1'b1;
        @(posedge clk); #1 set_pulse = 1'b0; inc_pulse = 1'b0;
        expect_out("sim_pulse", 2'b11, 16'h2001, 1'b0, 1'b1, 3'd2);

        // Leap year: 2004-02-28 23:59 + 60 s.
        do_reset();
        set_datetime(4, 2, 28, 23, 59);
        run_minute_and_freeze();
        expect_out("leap_date", 2'b10, 16'h0229, 1'b0, 1'b0, 3'd1);
        expect_out("leap_year", 2'b11, 16'h2004, 1'b0, 1'b0, 3'd1);
        expect_out("h12_zero",  2'b01, 16'h1200, 1'b0, 1'b0, 3'd1);

        // Non-leap year: 2001-02-28 23:59 + 60 s.
        do_reset();
        set_datetime(1, 2, 28, 23, 59);
        run_minute_and_freeze();
        expect_out("nonleap_date", 2'b10, 16'h0301, 1'b0, 1'b0, 3'd1);
        expect_out("nonleap_year", 2'b11, 16'h2001, 1'b0, 1'b0, 3'd1);

        // 12h/24h decode of hour 13.
        do_reset();
        set_datetime(0, 1, 1, 13, 5);
        expect_out("h12_pm", 2'b01, 16'h0105, 1'b1, 1'b0, 3'd5);
        pulse_mode();
        expect_out("h24_pm", 2'b01, 16'h1305, 1'b1, 1'b1, 3'd5);

        // Day clamp: 2001-01-31, then month -> 02.
        do_reset();
        pulse_set();
        pulse_inc();
        pulse_set();
        pulse_set();
        repeat (30) pulse_inc();
        pulse_set();
        pulse_set();
        pulse_set();
        pulse_set();
        pulse_set();
        pulse_inc();
        expect_out("clamp_pre", 2'b10, 16'h0231, 1'b0, 1'b0, 3'd2);
        pulse_set();
        expect_out("clamp_day", 2'b10, 16'h0228, 1'b0, 1'b0, 3'd3);

        // Reset while setting HOUR = 12.
        do_reset();
        repeat (4) pulse_set();
        repeat (12) pulse_inc();
        expect_out("pre_reset", 2'b01, 16'h1200, 1'b1, 1'b0, 3'd4);
        @(posedge clk); #1 rst_n = 1'b0;
        expect_out("rst_mid_hhmm", 2'b01, 16'h1200, 1'b0, 1'b0, 3'd0);
        expect_out("rst_mid_date", 2'b10, 16'h0101, 1'b0, 1'b0, 3'd0);
        expect_out("rst_mid_year", 2'b11, 16'h2000, 1'b0, 1'b0, 3'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Final accounting of monitor results.
        if (checks < 12) begin
            errors++;
            $display("FAIL check_count: only %0d checks executed", checks);
        end else begin
            $display("INFO check_count: %0d checks executed", checks);
        end
        if (errors == 0) begin
            $display("PASS: all checks passed");
        end else begin
            $display("FAIL: %0d errors", errors);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
